// File: rtl/pc_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pc_unit: fetch-stage program counter with byte stepping, stall, redirects, |
// |          trap vector, circular return-address stack and misalign check.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pc_unit #(
   parameter int               WIDTH     = 32,
   parameter int               STEP      = 4,
   parameter logic [WIDTH-1:0] RESET_VEC = '0,
   parameter logic [WIDTH-1:0] TRAP_VEC  = WIDTH'(32'h100),
   parameter int               RAS_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             trap,
   input  logic             branch,
   input  logic             br_rel,
   input  logic [WIDTH-1:0] br_addr,
   input  logic             link,
   input  logic             ret,
   output logic [WIDTH-1:0] pc_out,
   output logic             ras_empty,
   output logic             ras_full,
   output logic             misalign,
   output logic             ras_uflow
);

   localparam int c_ptr_w = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int c_cnt_w = $clog2(RAS_DEPTH + 1);

   localparam logic [WIDTH-1:0]   c_step       = WIDTH'(STEP);
   localparam logic [WIDTH-1:0]   c_align_mask = WIDTH'(STEP - 1);
   localparam logic [c_cnt_w-1:0] c_depth      = c_cnt_w'(RAS_DEPTH);
   localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);
   localparam logic [c_ptr_w-1:0] c_ptr_last   = c_ptr_w'(RAS_DEPTH - 1);
   localparam logic [c_ptr_w-1:0] c_ptr_one    = c_ptr_w'(1);

   logic [WIDTH-1:0]   r_pc;
   logic [c_ptr_w-1:0] r_tp;
   logic [c_cnt_w-1:0] r_cnt;
   logic [WIDTH-1:0]   r_ras [RAS_DEPTH];
   logic               r_misalign;
   logic               r_ras_uflow;

   logic [WIDTH-1:0]   w_seq;
   logic [WIDTH-1:0]   w_target;
   logic               w_target_mis;
   logic               w_active;
   logic               w_push;
   logic               w_pop;
   logic               w_ras_empty;
   logic [c_ptr_w-1:0] w_tp_inc;
   logic [c_ptr_w-1:0] w_tp_dec;

   assign w_seq        = r_pc + c_step;
   assign w_target     = br_rel ? (r_pc + br_addr) : br_addr;
   assign w_target_mis = |(w_target & c_align_mask);
   assign w_ras_empty  = (r_cnt == '0);

   // Only a cycle free of trap and stall may touch the RAS.
   assign w_active = !trap && !stall;
   assign w_push   = w_active && branch && link && !w_target_mis;
   assign w_pop    = w_active && !branch && ret && !w_ras_empty;

   // tp indexes the top entry; pushes pre-increment, so a full push overwrites the oldest.
   assign w_tp_inc = (r_tp == c_ptr_last) ? '0 : (r_tp + c_ptr_one);
   assign w_tp_dec = (r_tp == '0) ? c_ptr_last : (r_tp - c_ptr_one);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_ras[w_tp_inc] <= w_seq;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc        <= RESET_VEC;
         r_tp        <= '0;
         r_cnt       <= '0;
         r_misalign  <= 1'b0;
         r_ras_uflow <= 1'b0;
      end else begin
         r_misalign  <= 1'b0;
         r_ras_uflow <= 1'b0;
         if (trap) begin
            r_pc <= TRAP_VEC;
         end else if (stall) begin
            r_pc <= r_pc;
         end else if (branch) begin
            if (w_target_mis) begin
               r_pc       <= TRAP_VEC;
               r_misalign <= 1'b1;
            end else begin
               r_pc <= w_target;
            end
            if (w_push) begin
               r_tp <= w_tp_inc;
               if (r_cnt != c_depth) begin
                  r_cnt <= r_cnt + c_cnt_one;
               end
            end
         end else if (ret) begin
            if (w_pop) begin
               r_pc  <= r_ras[r_tp];
               r_tp  <= w_tp_dec;
               r_cnt <= r_cnt - c_cnt_one;
            end else begin
               r_pc        <= w_seq;
               r_ras_uflow <= 1'b1;
            end
         end else begin
            r_pc <= w_seq;
         end
      end
   end

   assign pc_out    = r_pc;
   assign ras_empty = w_ras_empty;
   assign ras_full  = (r_cnt == c_depth);
   assign misalign  = r_misalign;
   assign ras_uflow = r_ras_uflow;

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pc_unit: directed scoreboard bench for pc_unit (32-bit and 8-bit DUTs). |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_pc_unit;

   typedef struct {
      int          id;
      logic [31:0] pc;
      logic        mis;
      logic        uf;
      logic        emp;
      logic        full;
      logic        chk8;
      logic [7:0]  pc8;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, trap, branch, br_rel, link, ret;
   logic [31:0] br_addr;
   logic [31:0] pc_out;
   logic        ras_empty, ras_full, misalign, ras_uflow;

   logic [7:0]  pc8;
   logic [7:0]  zero8 = 8'h00;
   logic        zero1 = 1'b0;
   logic        emp8, full8, mis8, uf8;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   pc_unit #(.WIDTH(32), .STEP(4), .RESET_VEC(32'h0), .TRAP_VEC(32'h100), .RAS_DEPTH(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .trap(trap), .branch(branch),
      .br_rel(br_rel), .br_addr(br_addr), .link(link), .ret(ret),
      .pc_out(pc_out), .ras_empty(ras_empty), .ras_full(ras_full),
      .misalign(misalign), .ras_uflow(ras_uflow)
   );

   pc_unit #(.WIDTH(8), .STEP(4), .RESET_VEC(8'hF4), .TRAP_VEC(8'h80), .RAS_DEPTH(2)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .stall(zero1), .trap(zero1), .branch(zero1),
      .br_rel(zero1), .br_addr(zero8), .link(zero1), .ret(zero1),
      .pc_out(pc8), .ras_empty(emp8), .ras_full(full8),
      .misalign(mis8), .ras_uflow(uf8)
   );

   task automatic check(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", nm, id, act, exp);
      end
   endtask

   // Monitor: outputs are sampled on the falling edge, away from the update edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            check("pc_out",    e.id, pc_out,           e.pc);
            check("misalign",  e.id, {31'b0, misalign},  {31'b0, e.mis});
            check("ras_uflow", e.id, {31'b0, ras_uflow}, {31'b0, e.uf});
            check("ras_empty", e.id, {31'b0, ras_empty}, {31'b0, e.emp});
            check("ras_full",  e.id, {31'b0, ras_full},  {31'b0, e.full});
            if (e.chk8) check("pc8", e.id, {24'b0, pc8}, {24'b0, e.pc8});
         end
      end
   end

   task automatic push_exp(input int id, input logic [31:0] epc, input logic emis, input logic euf,
                           input logic eemp, input logic efull, input logic c8, input logic [7:0] e8);
      exp_t e;
      e.id = id; e.pc = epc; e.mis = emis; e.uf = euf; e.emp = eemp; e.full = efull;
      e.chk8 = c8; e.pc8 = e8;
      q.push_back(e);
   endtask

   // Drive one request for one edge, then queue the response expected after that edge.
   task automatic step(input int id, input logic s, input logic t, input logic b, input logic rel,
                       input logic [31:0] a, input logic l, input logic r,
                       input logic [31:0] epc, input logic emis, input logic euf,
                       input logic eemp, input logic efull, input logic c8, input logic [7:0] e8);
      stall = s; trap = t; branch = b; br_rel = rel; br_addr = a; link = l; ret = r;
      @(posedge clk);
      push_exp(id, epc, emis, euf, eemp, efull, c8, e8);
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      stall = 0; trap = 0; branch = 0; br_rel = 0; br_addr = '0; link = 0; ret = 0;
      repeat (2) @(negedge clk);
      push_exp(0, 32'h0, 0, 0, 1, 0, 1, 8'hF4);
      @(negedge clk);
      rst_n = 1'b1;
      //    id  s  t  b  rel addr          l  r  pc            mis uf emp full c8 pc8
      step(1,  0, 0, 0, 0, 32'h0,        0, 0, 32'h4,        0, 0, 1, 0, 1, 8'hF8);
      step(2,  0, 0, 0, 0, 32'h0,        0, 0, 32'h8,        0, 0, 1, 0, 1, 8'hFC);
      step(3,  0, 0, 0, 0, 32'h0,        0, 0, 32'hC,        0, 0, 1, 0, 1, 8'h00);
      step(4,  0, 0, 1, 0, 32'h40,       0, 0, 32'h40,       0, 0, 1, 0, 0, 8'h00);
      step(5,  0, 0, 1, 1, 32'hFFFFFFF8, 0, 0, 32'h38,       0, 0, 1, 0, 0, 8'h00);
      step(6,  1, 0, 0, 0, 32'h0,        0, 0, 32'h38,       0, 0, 1, 0, 0, 8'h00);
      step(7,  1, 0, 0, 0, 32'h0,        0, 0, 32'h38,       0, 0, 1, 0, 0, 8'h00);
      step(8,  1, 1, 0, 0, 32'h0,        0, 0, 32'h100,      0, 0, 1, 0, 0, 8'h00);
      step(9,  0, 0, 1, 0, 32'h10,       0, 0, 32'h10,       0, 0, 1, 0, 0, 8'h00);
      step(10, 0, 0, 1, 0, 32'h80,       1, 0, 32'h80,       0, 0, 0, 0, 0, 8'h00);
      step(11, 0, 0, 0, 0, 32'h0,        0, 1, 32'h14,       0, 0, 1, 0, 0, 8'h00);
      // Five calls: return addresses 0x18, 0x204, 0x304, 0x404, 0x504; the first is overwritten.
      step(12, 0, 0, 1, 0, 32'h200,      1, 0, 32'h200,      0, 0, 0, 0, 0, 8'h00);
      step(13, 0, 0, 1, 0, 32'h300,      1, 0, 32'h300,      0, 0, 0, 0, 0, 8'h00);
      step(14, 0, 0, 1, 0, 32'h400,      1, 0, 32'h400,      0, 0, 0, 0, 0, 8'h00);
      step(15, 0, 0, 1, 0, 32'h500,      1, 0, 32'h500,      0, 0, 0, 1, 0, 8'h00);
      step(16, 0, 0, 1, 0, 32'h600,      1, 0, 32'h600,      0, 0, 0, 1, 0, 8'h00);
      step(17, 0, 0, 0, 0, 32'h0,        0, 1, 32'h504,      0, 0, 0, 0, 0, 8'h00);
      step(18, 0, 0, 0, 0, 32'h0,        0, 1, 32'h404,      0, 0, 0, 0, 0, 8'h00);
      step(19, 0, 0, 0, 0, 32'h0,        0, 1, 32'h304,      0, 0, 0, 0, 0, 8'h00);
      step(20, 0, 0, 0, 0, 32'h0,        0, 1, 32'h204,      0, 0, 1, 0, 0, 8'h00);
      step(21, 0, 0, 0, 0, 32'h0,        0, 1, 32'h208,      0, 1, 1, 0, 0, 8'h00);
      step(22, 0, 0, 0, 0, 32'h0,        0, 0, 32'h20C,      0, 0, 1, 0, 0, 8'h00);
      step(23, 0, 0, 1, 0, 32'h40,       1, 0, 32'h40,       0, 0, 0, 0, 0, 8'h00);
      step(24, 0, 0, 1, 0, 32'h82,       1, 0, 32'h100,      1, 0, 0, 0, 0, 8'h00);
      step(25, 0, 0, 0, 0, 32'h0,        0, 0, 32'h104,      0, 0, 0, 0, 0, 8'h00);
      step(26, 0, 0, 1, 0, 32'h300,      0, 1, 32'h300,      0, 0, 0, 0, 0, 8'h00);
      step(27, 0, 0, 0, 0, 32'h0,        0, 1, 32'h210,      0, 0, 1, 0, 0, 8'h00);
      step(28, 0, 0, 1, 1, 32'h2,        1, 0, 32'h100,      1, 0, 1, 0, 0, 8'h00);
      step(29, 0, 0, 0, 0, 32'h0,        1, 0, 32'h104,      0, 0, 1, 0, 0, 8'h00);
      step(30, 0, 0, 1, 0, 32'h40,       1, 0, 32'h40,       0, 0, 0, 0, 0, 8'h00);
      // Asynchronous reset between edges with a branch pending.
      stall = 0; trap = 0; branch = 1; br_rel = 0; br_addr = 32'h700; link = 1; ret = 0;
      #1 rst_n = 1'b0;
      push_exp(31, 32'h0, 0, 0, 1, 0, 0, 8'h00);
      @(negedge clk);
      branch = 0; link = 0; br_addr = '0;
      @(negedge clk);
      rst_n = 1'b1;
      step(32, 0, 0, 0, 0, 32'h0,        0, 0, 32'h4,        0, 0, 1, 0, 0, 8'h00);
      repeat (3) @(negedge clk);
      if (q.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain: %0d expected responses left unchecked, required 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the fetch stage: the successor to the simple increment/branch counter. It adds byte-addressed stepping, stall, absolute and PC-relative redirects, a trap vector, a return-address stack (RAS) for call/return, and misaligned-target detection. It drives the instruction-memory address and takes redirect requests from the execute stage.

## Interface
- WIDTH, 32: PC and address width in bits.
- STEP, 4: increment in bytes. Must be a power of two ≥1; ALIGN = log2(STEP).
- RESET_VEC, 0: PC value after reset.
- TRAP_VEC, 'h100: PC value loaded on a trap or on a misaligned redirect.
- RAS_DEPTH, 4: return-address stack entries, ≥2.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  hold the PC and the RAS for this cycle.
- trap  in  1  redirect to TRAP_VEC.
- branch  in  1  redirect request.
- br_rel  in  1  with branch: 1 = target is pc_out + br_addr (signed), 0 = target is br_addr.
- br_addr  in  WIDTH  absolute target or two's-complement offset.
- link  in  1  with branch: push pc_out + STEP onto the RAS (call).
- ret  in  1  pop the RAS top into the PC (return).
- pc_out  out  WIDTH  current PC (registered).
- ras_empty  out  1  RAS holds no entries (combinational from the count).
- ras_full  out  1  RAS holds RAS_DEPTH entries.
- misalign  out  1  one-cycle pulse: the previous cycle's redirect target was misaligned.
- ras_uflow  out  1  one-cycle pulse: a ret was taken while the RAS was empty.

## Operation
- Priority each cycle, highest first: trap, stall, branch, ret, sequential.
- **trap:** pc_out ← TRAP_VEC. Takes effect even when stall=1. RAS unchanged.
- **stall** (no trap): pc_out and the RAS hold. misalign and ras_uflow are 0.
- **branch:** target = br_rel ? pc_out + br_addr : br_addr, computed mod 2^WIDTH.
  - If target[ALIGN-1:0] ≠ 0: pc_out ← TRAP_VEC, misalign=1 next cycle, and no push occurs even if link=1.
  - Otherwise pc_out ← target. If link=1, push pc_out + STEP (the pre-update PC).
  - A ret asserted in the same cycle is ignored; no pop occurs.
- **ret** (branch=0):
  - RAS non-empty: pc_out ← top, then pop.
  - RAS empty: pc_out ← pc_out + STEP and ras_uflow=1 next cycle.
- **sequential:** pc_out ← pc_out + STEP, wrapping mod 2^WIDTH (all-ones region wraps to 0).
- **RAS structure:** circular buffer with pointer tp and count cnt (0..RAS_DEPTH).
  - Push when full overwrites the oldest entry and cnt stays at RAS_DEPTH. No error is flagged.
  - Pop decrements cnt. Entries are not cleared.
- link without branch is ignored.

## Timing
- Reset (rst_n=0, asynchronous): pc_out=RESET_VEC, cnt=0, tp=0, misalign=0, ras_uflow=0. Hence ras_empty=1 and ras_full=0.
- Release: the first rising edge with rst_n=1 performs a normal update, so pc_out becomes RESET_VEC+STEP unless some other request is active.
- Latency: one cycle. A request sampled at edge N is visible on pc_out after edge N.
- misalign and ras_uflow are registered and assert in the same cycle that pc_out shows the resulting value.
- ras_empty and ras_full reflect cnt after the last edge.
- Reset asserted mid-stream clears everything immediately; pending requests are discarded.
- No handshake: every request is single-cycle and level-sampled. The requester must deassert after one cycle or the action repeats; a held link, for example, pushes every cycle.

## Test plan
- Reset → pc_out=0. Release with no requests, 3 edges → pc_out = 4, 8, 12. With WIDTH=8 and PC 'hFC, the next edge gives 'h00.
- At pc_out=0x40: branch, br_rel=1, br_addr=-8 → 0x38. Then stall for 2 cycles → 0x38 held. Then trap together with stall → 0x100.
- Call/return: at PC 0x10, branch+link to 0x80 → PC 0x80 and RAS holds 0x14. Then ret → PC 0x14, ras_empty=1.
- With RAS_DEPTH=4, push 5 calls with return addresses A1..A5 → ras_full=1. Then 4 rets → PC A5, A4, A3, A2. A fifth ret → PC+4 and ras_uflow pulses 1.
- Branch to 0x82 with link=1 → PC 0x100, misalign=1 for exactly one cycle, RAS count unchanged.
- Branch and ret in the same cycle with a non-empty RAS → PC = branch target, count unchanged. Assert rst_n=0 between edges → pc_out=RESET_VEC immediately and ras_empty=1.
